firebird7_in_gate1_tessent_data_mux_ctrl: RTL

- IJTAG test data register (TDR) controller that drives the select and override-data inputs of the instrument's W-bit IJTAG data mux.
- Provides capture, shift and update of an override word, and an observe path of the functional data.
- Adds a pulse mode: the mux is held in IJTAG override for a programmed number of TCK cycles, then released automatically.
- Sits in the gate1 IJTAG network between the parent SIB/scan mux and the data mux instance.

---
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR controller for the gate1 data mux: capture/shift/update of an override word,
// with an optional self-releasing pulse mode that holds the mux in override for N TCK cycles.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic         ijtag_tck,
  input  logic         ijtag_reset,
  input  logic         ijtag_sel,
  input  logic         ijtag_ce,
  input  logic         ijtag_se,
  input  logic         ijtag_ue,
  input  logic         ijtag_si,
  output logic         ijtag_so,
  input  logic [W-1:0] functional_data_in,
  output logic         ijtag_select,
  output logic [W-1:0] ijtag_data_out,
  output logic         pulse_active
);

  localparam int unsigned L = W + CNT_W + 2;

  typedef enum logic [1:0] {StIdle, StStatic, StPulse} state_e;

  state_e             state_q, state_d;
  logic [L-1:0]       shift_q, shift_d;
  logic               select_q, select_d;
  logic [W-1:0]       data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;

  logic               do_cap, do_shift, do_upd;
  logic               req_sel, req_pulse;
  logic [W-1:0]       req_data;
  logic [CNT_W-1:0]   req_len;

  assign do_cap   = ijtag_sel & ijtag_ce;
  assign do_shift = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign do_upd   = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

  assign req_sel   = shift_q[0];
  assign req_pulse = shift_q[1];
  assign req_data  = shift_q[W+1:2];
  assign req_len   = shift_q[L-1:W+2];

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    select_d = select_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    active_d = active_q;

    if (do_cap) begin
      shift_d = {cnt_q, functional_data_in, active_q, select_q};
    end else if (do_shift) begin
      shift_d = {ijtag_si, shift_q[L-1:1]};
    end

    // An update always wins over the running countdown.
    if (do_upd) begin
      data_d = req_data;
      if (!req_pulse) begin
        select_d = req_sel;
        cnt_d    = '0;
        active_d = 1'b0;
        state_d  = req_sel ? StStatic : StIdle;
      end else if (req_len != '0) begin
        select_d = 1'b1;
        cnt_d    = req_len;
        active_d = 1'b1;
        state_d  = StPulse;
      end else begin
        select_d = 1'b0;
        cnt_d    = '0;
        active_d = 1'b0;
        state_d  = StIdle;
      end
    end else if (state_q == StPulse) begin
      if (cnt_q == CNT_W'(1)) begin
        select_d = 1'b0;
        cnt_d    = '0;
        active_d = 1'b0;
        state_d  = StIdle;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      select_q <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      select_q <= select_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign ijtag_so       = shift_q[0];
  assign ijtag_select   = select_q;
  assign ijtag_data_out = data_q;
  assign pulse_active   = active_q;

endmodule
